// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate block: FSM state encoding
// and the default parameter values used by mac_accumulator.
package mac_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_N_TERMS = 4;
  localparam int DEFAULT_ACC_W   = 20;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/parallel_multiplier.sv
// Combinational 8x8 unsigned multiplier producing a full 16-bit product.
// Built as a sum of shifted partial products, one per multiplicand bit.
module parallel_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Sum the partial products b << i for every set bit i of a.
  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) begin
        p = p + ({8'd0, b} << i);
      end
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate engine: accepts N_TERMS operand pairs, sums their
// products modulo 2^ACC_W, and presents the sum with a sticky carry flag.
// Products are registered one cycle before being added, so the last product
// is folded in during a single FLUSH cycle before the result is offered.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int N_TERMS = DEFAULT_N_TERMS,
  parameter int ACC_W   = DEFAULT_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = ACC_W + 1;
  localparam int CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                prod_pend_q, prod_pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [PROD_W-1:0]   product;
  logic [SUM_W-1:0]    acc_sum;
  logic                in_hs;
  logic                out_hs;

  // The 8-bit configuration uses the shared array multiplier; other widths
  // fall back to a plain multiply.
  generate
    if (WIDTH == 8) begin : g_mul8
      parallel_multiplier u_mul (
        .a (a_in),
        .b (b_in),
        .p (product)
      );
    end else begin : g_mul_generic
      assign product = PROD_W'(a_in) * PROD_W'(b_in);
    end
  endgenerate

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Next-state and datapath: clear overrides everything, otherwise fold in
  // any pending product and advance the FSM on handshakes.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prod_pend_d = prod_pend_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_sum     = SUM_W'(acc_q) + SUM_W'(prod_q);

    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      prod_pend_d = 1'b0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end else begin
      if (prod_pend_q) begin
        acc_d       = acc_sum[ACC_W-1:0];
        ovf_d       = ovf_q | acc_sum[ACC_W];
        prod_pend_d = 1'b0;
      end

      unique case (state_q)
        ACCUM: begin
          if (in_hs) begin
            prod_d      = product;
            prod_pend_d = 1'b1;
            if (cnt_q == LAST_TERM) begin
              cnt_d   = '0;
              state_d = FLUSH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          state_d = DONE;
        end
        DONE: begin
          if (out_hs) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_pend_q <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_pend_q <= prod_pend_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed testbench for mac_accumulator: a default-parameter instance plus
// a 16-bit-accumulator instance for the wrap/overflow scenario.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, clear, out_valid, out_ready, ovf;
  logic [7:0]  a_in, b_in;
  logic [19:0] acc_out;

  logic        w_in_valid, w_in_ready, w_clear, w_out_valid, w_out_ready, w_ovf;
  logic [7:0]  w_a_in, w_b_in;
  logic [15:0] w_acc_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf)
  );

  mac_accumulator #(.WIDTH(8), .N_TERMS(4), .ACC_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a_in      (w_a_in),
    .b_in      (w_b_in),
    .clear     (w_clear),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .acc_out   (w_acc_out),
    .ovf       (w_ovf)
  );

  // Present one pair for one cycle, starting at a falling edge.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // The four reference pairs summing to 0x17F7F, with optional idle gaps.
  task automatic send_ref_pairs(input int gap);
    send_pair(8'hFF, 8'h06);
    repeat (gap) @(negedge clk);
    send_pair(8'hFF, 8'hCD);
    repeat (gap) @(negedge clk);
    send_pair(8'hFF, 8'hAA);
    repeat (gap) @(negedge clk);
    send_pair(8'h06, 8'hAA);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; a_in = '0; b_in = '0; clear = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_a_in = '0; w_b_in = '0; w_clear = 1'b0; w_out_ready = 1'b0;
    #2;
    total++;
    if ({in_ready, out_valid, acc_out, ovf} !== {1'b1, 1'b0, 20'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_outputs actual rdy=%b vld=%b acc=%h ovf=%b required rdy=1 vld=0 acc=0 ovf=0",
               in_ready, out_valid, acc_out, ovf);
    end
    total++;
    if ({w_in_ready, w_out_valid, w_acc_out, w_ovf} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_outputs16 actual rdy=%b vld=%b acc=%h ovf=%b required rdy=1 vld=0 acc=0 ovf=0",
               w_in_ready, w_out_valid, w_acc_out, w_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_ref_pairs(0);
    total++;
    if ({out_valid, in_ready} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL b2b_flush actual vld=%b rdy=%b required vld=0 rdy=0", out_valid, in_ready);
    end
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, acc_out, ovf} !== {1'b1, 1'b0, 20'h17F7F, 1'b0}) begin
      bad++;
      $display("[TB] FAIL b2b_result actual vld=%b rdy=%b acc=%h ovf=%b required vld=1 rdy=0 acc=17f7f ovf=0",
               out_valid, in_ready, acc_out, ovf);
    end
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, acc_out} !== {1'b0, 1'b1, 20'h0}) begin
      bad++;
      $display("[TB] FAIL b2b_after actual vld=%b rdy=%b acc=%h required vld=0 rdy=1 acc=0",
               out_valid, in_ready, acc_out);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send_ref_pairs(0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_valid, in_ready, acc_out, ovf} !== {1'b1, 1'b0, 20'h17F7F, 1'b0}) begin
        bad++;
        $display("[TB] FAIL stall_hold cycle=%0d actual vld=%b rdy=%b acc=%h ovf=%b required vld=1 rdy=0 acc=17f7f ovf=0",
                 i, out_valid, in_ready, acc_out, ovf);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL stall_release actual vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_wrap();
    w_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_a_in = 8'hFF; w_b_in = 8'hFF; w_in_valid = 1'b1;
      @(negedge clk);
    end
    w_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({w_out_valid, w_acc_out, w_ovf} !== {1'b1, 16'hF804, 1'b1}) begin
      bad++;
      $display("[TB] FAIL wrap_result actual vld=%b acc=%h ovf=%b required vld=1 acc=f804 ovf=1",
               w_out_valid, w_acc_out, w_ovf);
    end
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
    total++;
    if ({w_acc_out, w_ovf, w_in_ready} !== {16'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL wrap_handshake actual acc=%h ovf=%b rdy=%b required acc=0 ovf=0 rdy=1",
               w_acc_out, w_ovf, w_in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      w_a_in = 8'h01; w_b_in = 8'h01; w_in_valid = 1'b1;
      @(negedge clk);
    end
    w_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({w_out_valid, w_acc_out, w_ovf} !== {1'b1, 16'h0004, 1'b0}) begin
      bad++;
      $display("[TB] FAIL wrap_next actual vld=%b acc=%h ovf=%b required vld=1 acc=0004 ovf=0",
               w_out_valid, w_acc_out, w_ovf);
    end
    w_out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send_pair(8'hFF, 8'h06);
    send_pair(8'hFF, 8'h06);
    // An offered pair alongside clear must be dropped.
    clear = 1'b1;
    a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    total++;
    if ({acc_out, ovf, in_ready, out_valid} !== {20'h0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL clear_state actual acc=%h ovf=%b rdy=%b vld=%b required acc=0 ovf=0 rdy=1 vld=0",
               acc_out, ovf, in_ready, out_valid);
    end
    @(negedge clk);
    total++;
    if (acc_out !== 20'h0) begin
      bad++;
      $display("[TB] FAIL clear_discard actual acc=%h required acc=0", acc_out);
    end
    for (int i = 0; i < 4; i++) send_pair(8'h01, 8'h02);
    @(negedge clk);
    total++;
    if ({out_valid, acc_out} !== {1'b1, 20'h00008}) begin
      bad++;
      $display("[TB] FAIL clear_result actual vld=%b acc=%h required vld=1 acc=00008", out_valid, acc_out);
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    send_ref_pairs(2);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL gaps_flush actual vld=%b required vld=0", out_valid);
    end
    @(negedge clk);
    total++;
    if ({out_valid, acc_out, ovf} !== {1'b1, 20'h17F7F, 1'b0}) begin
      bad++;
      $display("[TB] FAIL gaps_result actual vld=%b acc=%h ovf=%b required vld=1 acc=17f7f ovf=0",
               out_valid, acc_out, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_pair(8'hFF, 8'h06);
    send_pair(8'hFF, 8'hCD);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, acc_out, ovf} !== {1'b1, 1'b0, 20'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rst_midsum actual rdy=%b vld=%b acc=%h ovf=%b required rdy=1 vld=0 acc=0 ovf=0",
               in_ready, out_valid, acc_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_ref_pairs(0);
    @(negedge clk);
    total++;
    if ({out_valid, acc_out} !== {1'b1, 20'h17F7F}) begin
      bad++;
      $display("[TB] FAIL rst_resume actual vld=%b acc=%h required vld=1 acc=17f7f", out_valid, acc_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, acc_out, ovf} !== {1'b1, 1'b0, 20'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rst_done actual rdy=%b vld=%b acc=%h ovf=%b required rdy=1 vld=0 acc=0 ovf=0",
               in_ready, out_valid, acc_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_ref_pairs(0);
    @(negedge clk);
    total++;
    if ({out_valid, acc_out, ovf} !== {1'b1, 20'h17F7F, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rst_after_sum actual vld=%b acc=%h ovf=%b required vld=1 acc=17f7f ovf=0",
               out_valid, acc_out, ovf);
    end
    @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_clear();
    test_gaps();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
